regfile_mp: RTL and testbench

- Parameterised multi-read-port register file with one write port, a hardwired zero register, registered reads and write-first bypass.
- Carries a per-register pending (scoreboard) bit so decode can detect RAW hazards on in-flight destinations.
- Sits between decode (reads, issue marking) and writeback (write/clear) in the MIPS pipeline.
- Successor to the fixed 2-read, 32x32 register file.

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, optional hardwired zero
// register, registered reads with write-first bypass, and per-register pending bits.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     pend_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         pend_q, pend_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_RD-1:0]        rd_pending_q, rd_pending_d;
    logic                     pend_any_q, pend_any_d;
    logic                     wr_ok;

    logic [ADDR_W-1:0]        ra [NUM_RD];
    logic [NUM_RD-1:0]        wr_hit;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        assign ra[g]     = rd_addr[g*ADDR_W +: ADDR_W];
        assign wr_hit[g] = wr_en && (wr_addr == ra[g]);
    end

    always_comb begin
        wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
        // Issue is applied after the clear so a same-cycle issue keeps the bit set.
        for (int a = 0; a < DEPTH; a++) begin
            pend_d[a] = (pend_q[a] && !(wr_en && (wr_addr == ADDR_W'(a))))
                        || (iss_en && (iss_addr == ADDR_W'(a)));
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        pend_any_d = |pend_d;
    end

    always_comb begin
        rd_data_d    = rd_data_q;
        rd_pending_d = rd_pending_q;
        rd_valid_d   = rd_en;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                    rd_pending_d[i]               = 1'b0;
                end else begin
                    if ((BYPASS != 0) && wr_hit[i]) begin
                        rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                    end else begin
                        rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra[i]];
                    end
                    rd_pending_d[i] = pend_q[ra[i]] && !wr_hit[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
            pend_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            rd_pending_q <= '0;
            pend_any_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            pend_q       <= pend_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_pending_q <= rd_pending_d;
            pend_any_q   <= pend_any_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_pending = rd_pending_q;
    assign pend_any   = pend_any_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default and no-bypass instances share randomized stimulus
// against an array model; a 4-port 64-bit instance gets directed checks.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] a_rd_data, b_rd_data;
    logic [1:0]  a_rd_valid, b_rd_valid, a_rd_pending, b_rd_pending;
    logic        a_pend_any, b_pend_any;

    logic [3:0]   c_rd_en;
    logic [23:0]  c_rd_addr;
    logic [255:0] c_rd_data;
    logic [3:0]   c_rd_valid, c_rd_pending;
    logic         c_wr_en, c_iss_en, c_pend_any;
    logic [5:0]   c_wr_addr, c_iss_addr;
    logic [63:0]  c_wr_data;

    regfile_mp u_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_pending(a_rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(a_pend_any)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_pending(b_rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(b_pend_any)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4)) u_c (
        .clk(clk), .rst(rst), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_valid(c_rd_valid), .rd_pending(c_rd_pending), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .iss_en(c_iss_en), .iss_addr(c_iss_addr), .pend_any(c_pend_any)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model: register contents and outstanding-destination set.
    logic [31:0] m_mem  [32];
    logic        m_pend [32];
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    logic        ep [2];
    logic [1:0]  ev;
    logic        e_any;

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = '0;
            m_pend[k] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            ea[i] = '0;
            eb[i] = '0;
            ep[i] = 1'b0;
        end
        ev    = '0;
        e_any = 1'b0;
    endtask

    task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia);
        logic [4:0] r;
        logic       hit;
        rd_en    = en;
        rd_addr  = {a1, a0};
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        ev = en;
        for (int i = 0; i < 2; i++) begin
            if (en[i]) begin
                r   = (i == 0) ? a0 : a1;
                hit = we && (wa == r);
                if (r == 0) begin
                    ea[i] = '0;
                    eb[i] = '0;
                    ep[i] = 1'b0;
                end else begin
                    ea[i] = hit ? wd : m_mem[r];
                    eb[i] = m_mem[r];
                    ep[i] = m_pend[r] && !hit;
                end
            end
        end
        if (we && wa != 0) m_mem[wa] = wd;
        if (we) m_pend[wa] = 1'b0;
        if (ie && ia != 0) m_pend[ia] = 1'b1;
        e_any = 1'b0;
        for (int k = 0; k < 32; k++) e_any = e_any | m_pend[k];
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("a_data%0d", i), 64'(a_rd_data[i*32 +: 32]), 64'(ea[i]));
            check_val($sformatf("b_data%0d", i), 64'(b_rd_data[i*32 +: 32]), 64'(eb[i]));
            check_val($sformatf("a_pend%0d", i), 64'(a_rd_pending[i]), 64'(ep[i]));
            check_val($sformatf("b_pend%0d", i), 64'(b_rd_pending[i]), 64'(ep[i]));
        end
        check_val("a_valid", 64'(a_rd_valid), 64'(ev));
        check_val("b_valid", 64'(b_rd_valid), 64'(ev));
        check_val("a_pend_any", 64'(a_pend_any), 64'(e_any));
        check_val("b_pend_any", 64'(b_pend_any), 64'(e_any));
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom % 4 == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic c_drive(input logic [3:0] en, input logic [23:0] addrs, input logic we,
                           input logic [5:0] wa, input logic [63:0] wd,
                           input logic ie, input logic [5:0] ia);
        c_rd_en    = en;
        c_rd_addr  = addrs;
        c_wr_en    = we;
        c_wr_addr  = wa;
        c_wr_data  = wd;
        c_iss_en   = ie;
        c_iss_addr = ia;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        c_rd_en = '0; c_rd_addr = '0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_iss_en = 1'b0; c_iss_addr = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_val("rst_a_data", a_rd_data, 64'd0);
        check_val("rst_a_valid", 64'(a_rd_valid), 64'd0);
        check_val("rst_a_pend_any", 64'(a_pend_any), 64'd0);
        check_val("rst_c_data", c_rd_data[63:0], 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset state read-out
        drive(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t1_valid", 64'(a_rd_valid), 64'h3);
        check_val("t1_data", a_rd_data, 64'd0);

        // Plain write/read and zero register
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
        drive(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t2_r7", a_rd_data, 64'hDEADBEEF_DEADBEEF);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        drive(2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t2_r0", 64'(a_rd_data[31:0]), 64'd0);

        // Bypass vs no bypass
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
        drive(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0);
        check_val("t3_byp", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
        check_val("t3_nobyp", 64'(b_rd_data[31:0]), 64'h11);
        drive(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t3_nobyp_next", 64'(b_rd_data[31:0]), 64'hA5A5A5A5);

        // Issue then writeback
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        drive(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t4_pend", 64'(a_rd_pending[0]), 64'd1);
        check_val("t4_any", 64'(a_pend_any), 64'd1);
        drive(2'b01, 5'd9, 5'd0, 1'b1, 5'd9, 32'h42, 1'b0, 5'd0);
        check_val("t4_wb_data", 64'(a_rd_data[31:0]), 64'h42);
        check_val("t4_wb_pend", 64'(a_rd_pending[0]), 64'd0);
        check_val("t4_any_clr", 64'(a_pend_any), 64'd0);

        // Set wins over clear; r0 never pending
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'h77, 1'b1, 5'd4);
        drive(2'b10, 5'd0, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_val("t5_setwins", 64'(a_rd_pending[1]), 64'd1);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'h78, 1'b0, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        check_val("t5_r0_any", 64'(a_pend_any), 64'd0);

        // Asynchronous reset in the middle of a read
        drive(2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_a_data", a_rd_data, 64'd0);
        check_val("mid_rst_b_data", b_rd_data, 64'd0);
        check_val("mid_rst_valid", 64'(a_rd_valid), 64'd0);
        check_val("mid_rst_any", 64'(a_pend_any), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom), rnd_addr(), rnd_addr(), 1'($urandom), rnd_addr(), $urandom,
                  ($urandom % 3 == 0), rnd_addr());
        end
        idle();

        // Wide four-port instance
        c_drive(4'h0, 24'd0, 1'b1, 6'd1, 64'h0123456789ABCDEF, 1'b0, 6'd0);
        c_drive(4'h0, 24'd0, 1'b1, 6'd63, 64'hFFFF0000FFFF0000, 1'b0, 6'd0);
        c_drive(4'h0, 24'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd63);
        c_drive(4'hF, {6'd1, 6'd63, 6'd0, 6'd63}, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);
        check_val("c_p0", c_rd_data[63:0], 64'hFFFF0000FFFF0000);
        check_val("c_p1", c_rd_data[127:64], 64'd0);
        check_val("c_p2", c_rd_data[191:128], 64'hFFFF0000FFFF0000);
        check_val("c_p3", c_rd_data[255:192], 64'h0123456789ABCDEF);
        check_val("c_valid", 64'(c_rd_valid), 64'hF);
        check_val("c_pend", 64'(c_rd_pending), 64'h5);
        check_val("c_any", 64'(c_pend_any), 64'd1);
        c_drive(4'b1011, {6'd1, 6'd1, 6'd0, 6'd1}, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);
        check_val("c_hold_p0", c_rd_data[63:0], 64'h0123456789ABCDEF);
        check_val("c_hold_p2", c_rd_data[191:128], 64'hFFFF0000FFFF0000);
        check_val("c_hold_valid", 64'(c_rd_valid), 64'hB);
        check_val("c_hold_pend", 64'(c_rd_pending), 64'h4);
        c_drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd63}, 1'b1, 6'd63, 64'h5, 1'b0, 6'd0);
        check_val("c_wb_data", c_rd_data[63:0], 64'h5);
        check_val("c_wb_pend", 64'(c_rd_pending[0]), 64'd0);
        check_val("c_wb_any", 64'(c_pend_any), 64'd0);
        c_drive(4'h0, 24'd0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
